mlp_layer_sequencer: RTL and testbench

Sequencer for one fully-connected layer of the handwriting MLP. On `start` it steps a shared, externally instantiated multiply-accumulate unit through every (input, neuron) pair, producing input-vector and weight-memory read addresses plus MAC clear/enable strobes. After each neuron it applies fixed-point rescale, saturation and optional ReLU, writes the 16-bit result into the layer output buffer, and tracks the running argmax. It sits between the 784-word input buffer and weight ROM on one side and the 10-word result buffer read by the classifier and testbench on the other.

---
 rtl/mlp_layer_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: drives a shared MAC through one fully-connected layer,
// then rescales, saturates, optionally clamps and tracks the running argmax.
module mlp_layer_sequencer #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int RELU  = 1,
  localparam int IW = $clog2(N_IN),
  localparam int AW = $clog2(N_IN * N_OUT),
  localparam int JW = $clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [IW-1:0]         in_addr,
  output logic [AW-1:0]         w_addr,
  output logic                  mac_clr,
  output logic                  mac_en,
  input  logic signed [2*W-1:0] acc,
  output logic                  out_we,
  output logic [JW-1:0]         out_addr,
  output logic [W-1:0]          out_data,
  output logic [JW-1:0]         class_idx,
  output logic                  class_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_WB,
    S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [AW-1:0] w_q, w_d;
  logic mac_en_q;
  logic signed [W-1:0] best_q, best_d;
  logic [JW-1:0] best_idx_q, best_idx_d;
  logic [JW-1:0] class_idx_q, class_idx_d;
  logic class_valid_q, class_valid_d;

  logic signed [2*W-1:0] shifted, sat_max, sat_min;
  logic signed [W-1:0] sat, res;

  // Rescale and saturate; argmax uses sat, the buffer gets res
  always_comb begin
    sat_max = '0;
    sat_max[W-2:0] = '1;
    sat_min = '1;
    sat_min[W-2:0] = '0;
    shifted = acc >>> FRAC;
    if (shifted > sat_max) begin
      sat = sat_max[W-1:0];
    end else if (shifted < sat_min) begin
      sat = sat_min[W-1:0];
    end else begin
      sat = shifted[W-1:0];
    end
    res = sat;
    if (RELU != 0 && sat < 0) begin
      res = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    w_d = w_q;
    best_d = best_q;
    best_idx_d = best_idx_q;
    class_idx_d = class_idx_q;
    class_valid_d = class_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          i_d = '0;
          j_d = '0;
          w_d = '0;
          best_d = '0;
          best_idx_d = '0;
          class_valid_d = 1'b0;
        end
      end
      S_CLR: begin
        i_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (w_q == AW'(N_IN * N_OUT - 1)) begin
          w_d = '0;
        end else begin
          w_d = w_q + AW'(1);
        end
        if (i_q == IW'(N_IN - 1)) begin
          i_d = '0;
          state_d = S_DRAIN;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_WB;
      end
      S_WB: begin
        if (j_q == '0 || sat > best_q) begin
          best_d = sat;
          best_idx_d = j_q;
        end
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = S_FIN;
        end else begin
          j_d = j_q + JW'(1);
          state_d = S_CLR;
        end
      end
      S_FIN: begin
        class_idx_d = best_idx_q;
        class_valid_d = 1'b1;
        j_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q <= '0;
      j_q <= '0;
      w_q <= '0;
      mac_en_q <= 1'b0;
      best_q <= '0;
      best_idx_q <= '0;
      class_idx_q <= '0;
      class_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      w_q <= w_d;
      mac_en_q <= (state_q == S_RUN);
      best_q <= best_d;
      best_idx_q <= best_idx_d;
      class_idx_q <= class_idx_d;
      class_valid_q <= class_valid_d;
    end
  end

  // mac_en trails rd_en by one cycle to meet the sync-read data
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);
  assign rd_en = (state_q == S_RUN);
  assign mac_clr = (state_q == S_CLR);
  assign mac_en = mac_en_q;
  assign out_we = (state_q == S_WB);
  assign in_addr = i_q;
  assign w_addr = w_q;
  assign out_addr = j_q;
  assign out_data = out_we ? res : '0;
  assign class_idx = class_idx_q;
  assign class_valid = class_valid_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb_mlp_layer_sequencer: directed checks on two small layers with a
// scripted accumulator and one full-size layer with a behavioural MAC.
module tb_mlp_layer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] tab [0:3];
  bit sel;
  logic start_s;

  logic start_a, busy_a, done_a, rd_a, clr_a, en_a, we_a, cv_a;
  logic [1:0] ia_a, oa_a, ci_a;
  logic [3:0] wa_a;
  logic [15:0] od_a;
  logic [31:0] acc_a;

  logic start_b, busy_b, done_b, rd_b, clr_b, en_b, we_b, cv_b;
  logic [1:0] ia_b, oa_b, ci_b;
  logic [3:0] wa_b;
  logic [15:0] od_b;
  logic [31:0] acc_b;

  logic start_c, busy_c, done_c, rd_c, clr_c, en_c, we_c, cv_c;
  logic [9:0] ia_c;
  logic [12:0] wa_c;
  logic [3:0] oa_c, ci_c;
  logic [15:0] od_c;
  logic signed [31:0] acc_c;
  logic signed [15:0] xd_c, wd_c;

  assign start_a = start_s & ~sel;
  assign start_b = start_s & sel;
  assign acc_a = tab[oa_a];
  assign acc_b = tab[oa_b];

  logic o_busy, o_done, o_rd, o_clr, o_en, o_we, o_cv;
  logic [1:0] o_ia, o_oa, o_ci;
  logic [3:0] o_wa;
  logic [15:0] o_od;

  always_comb begin
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_rd = sel ? rd_b : rd_a;
    o_clr = sel ? clr_b : clr_a;
    o_en = sel ? en_b : en_a;
    o_we = sel ? we_b : we_a;
    o_cv = sel ? cv_b : cv_a;
    o_ia = sel ? ia_b : ia_a;
    o_oa = sel ? oa_b : oa_a;
    o_ci = sel ? ci_b : ci_a;
    o_wa = sel ? wa_b : wa_a;
    o_od = sel ? od_b : od_a;
  end

  mlp_layer_sequencer #(.N_IN(4), .N_OUT(3), .W(16), .FRAC(8), .RELU(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
    .done(done_a), .rd_en(rd_a), .in_addr(ia_a), .w_addr(wa_a),
    .mac_clr(clr_a), .mac_en(en_a), .acc(acc_a), .out_we(we_a),
    .out_addr(oa_a), .out_data(od_a), .class_idx(ci_a),
    .class_valid(cv_a)
  );

  mlp_layer_sequencer #(.N_IN(4), .N_OUT(3), .W(16), .FRAC(8), .RELU(0)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
    .done(done_b), .rd_en(rd_b), .in_addr(ia_b), .w_addr(wa_b),
    .mac_clr(clr_b), .mac_en(en_b), .acc(acc_b), .out_we(we_b),
    .out_addr(oa_b), .out_data(od_b), .class_idx(ci_b),
    .class_valid(cv_b)
  );

  mlp_layer_sequencer u_c (
    .clk(clk), .reset(reset), .start(start_c), .busy(busy_c),
    .done(done_c), .rd_en(rd_c), .in_addr(ia_c), .w_addr(wa_c),
    .mac_clr(clr_c), .mac_en(en_c), .acc(acc_c), .out_we(we_c),
    .out_addr(oa_c), .out_data(od_c), .class_idx(ci_c),
    .class_valid(cv_c)
  );

  function automatic logic signed [15:0] xval(input int i);
    return 16'(((i * 37) % 23) - 11);
  endfunction

  function automatic logic signed [15:0] wval(input int k);
    return 16'(((k * 53 + 7) % 29) - 14);
  endfunction

  always_ff @(posedge clk) begin
    if (rd_c) begin
      xd_c <= xval(int'(ia_c));
      wd_c <= wval(int'(wa_c));
    end
    if (clr_c) acc_c <= '0;
    else if (en_c) acc_c <= acc_c + xd_c * wd_c;
  end

  int done_at, done_cnt, rd_cnt, rd_bad, mac_bad, ovl, wr_cnt, clr_after;
  logic [1:0] wr_addr [0:3];
  logic [15:0] wr_data [0:3];
  logic busy_end, cv_end, cv_start;
  logic [1:0] ci_end;

  task automatic run_pass(input int inj, input bit hold);
    int mcnt;
    done_at = 0; done_cnt = 0; rd_cnt = 0; rd_bad = 0; mac_bad = 0;
    ovl = 0; wr_cnt = 0; clr_after = 0; mcnt = 0;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      start_s = hold || (k == inj);
      if (k == 1) cv_start = o_cv;
      if (o_clr && o_en) ovl++;
      if (o_clr) mcnt = 0;
      if (o_en) mcnt++;
      if (o_clr && k > 22 && clr_after == 0) clr_after = k;
      if (o_rd) begin
        if (o_wa != 4'(rd_cnt) || o_ia != 2'(rd_cnt % 4)) rd_bad++;
        rd_cnt++;
      end
      if (o_we) begin
        if (mcnt != 4) mac_bad++;
        if (wr_cnt < 4) begin
          wr_addr[wr_cnt] = o_oa;
          wr_data[wr_cnt] = o_od;
        end
        wr_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == 23) begin
        busy_end = o_busy;
        cv_end = o_cv;
        ci_end = o_ci;
      end
      @(negedge clk);
    end
    start_s = 1'b0;
  endtask

  task automatic test_reset_state;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, done_a, rd_a, clr_a, en_a, we_a, cv_a} !== 7'b0) begin
      errors++;
      $display("FAIL rst_strobes got %b exp 0",
               {busy_a, done_a, rd_a, clr_a, en_a, we_a, cv_a});
    end
    checks++;
    if ({ia_a, wa_a, oa_a, od_a, ci_a} !== 26'b0) begin
      errors++;
      $display("FAIL rst_values got %h exp 0", {ia_a, wa_a, oa_a, od_a, ci_a});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequencing;
    sel = 1'b0;
    tab[0] = 32'h00012380; tab[1] = 32'h7FFF0000;
    tab[2] = 32'hFFFFFE00; tab[3] = 32'h0;
    run_pass(0, 1'b0);
    checks++;
    if (done_at !== 22) begin errors++; $display("FAIL seq_done_at got %0d exp 22", done_at); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL seq_done_cnt got %0d exp 1", done_cnt); end
    checks++;
    if (rd_cnt !== 12 || rd_bad !== 0) begin
      errors++; $display("FAIL seq_reads got %0d bad %0d exp 12 bad 0", rd_cnt, rd_bad);
    end
    checks++;
    if (mac_bad !== 0 || ovl !== 0) begin
      errors++; $display("FAIL seq_mac got bad %0d ovl %0d exp 0 0", mac_bad, ovl);
    end
    checks++;
    if (wr_cnt !== 3 || wr_addr[0] !== 2'd0 || wr_addr[1] !== 2'd1 || wr_addr[2] !== 2'd2) begin
      errors++; $display("FAIL seq_writes got %0d writes exp 3 at 0,1,2", wr_cnt);
    end
    checks++;
    if (busy_end !== 1'b0 || cv_end !== 1'b1) begin
      errors++; $display("FAIL seq_end got busy %b cv %b exp 0 1", busy_end, cv_end);
    end
  endtask

  task automatic test_arith;
    checks++;
    if (wr_data[0] !== 16'h0123 || wr_data[1] !== 16'h7FFF || wr_data[2] !== 16'h0000) begin
      errors++; $display("FAIL arith_relu got %h %h %h exp 0123 7fff 0000",
                         wr_data[0], wr_data[1], wr_data[2]);
    end
    checks++;
    if (ci_end !== 2'd1) begin errors++; $display("FAIL arith_relu_idx got %0d exp 1", ci_end); end
    sel = 1'b1;
    run_pass(0, 1'b0);
    checks++;
    if (wr_data[0] !== 16'h0123 || wr_data[1] !== 16'h7FFF || wr_data[2] !== 16'hFFFE) begin
      errors++; $display("FAIL arith_signed got %h %h %h exp 0123 7fff fffe",
                         wr_data[0], wr_data[1], wr_data[2]);
    end
    tab[0] = 32'hFFFFFE00; tab[1] = 32'h80000000; tab[2] = 32'h0000007F;
    run_pass(0, 1'b0);
    checks++;
    if (wr_data[0] !== 16'hFFFE || wr_data[1] !== 16'h8000 || wr_data[2] !== 16'h0000) begin
      errors++; $display("FAIL arith_negsat got %h %h %h exp fffe 8000 0000",
                         wr_data[0], wr_data[1], wr_data[2]);
    end
    checks++;
    if (ci_end !== 2'd2) begin errors++; $display("FAIL arith_negsat_idx got %0d exp 2", ci_end); end
    sel = 1'b0;
  endtask

  task automatic test_argmax;
    sel = 1'b0;
    tab[0] = 32'h00000500; tab[1] = 32'h00000900; tab[2] = 32'h00000900;
    run_pass(0, 1'b0);
    checks++;
    if (cv_start !== 1'b0) begin errors++; $display("FAIL argmax_cv_clear got %b exp 0", cv_start); end
    checks++;
    if (ci_end !== 2'd1 || wr_data[2] !== 16'h0009) begin
      errors++; $display("FAIL argmax_tie got idx %0d data %h exp 1 0009", ci_end, wr_data[2]);
    end
    tab[0] = 32'hFFFFFD00; tab[1] = 32'hFFFFFF00; tab[2] = 32'hFFFFFE00;
    run_pass(0, 1'b0);
    checks++;
    if (ci_end !== 2'd1 || cv_end !== 1'b1) begin
      errors++; $display("FAIL argmax_neg got idx %0d cv %b exp 1 1", ci_end, cv_end);
    end
    checks++;
    if (wr_data[0] !== 16'h0 || wr_data[1] !== 16'h0 || wr_data[2] !== 16'h0) begin
      errors++; $display("FAIL argmax_neg_relu got %h %h %h exp 0 0 0",
                         wr_data[0], wr_data[1], wr_data[2]);
    end
  endtask

  task automatic test_reset_midrun;
    int bad;
    sel = 1'b0;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL mid_running got rd %b busy %b exp 1 1", rd_a, busy_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, rd_a, clr_a, en_a, we_a, cv_a} !== 7'b0) begin
      errors++; $display("FAIL mid_rst_strobes got %b exp 0",
                         {busy_a, done_a, rd_a, clr_a, en_a, we_a, cv_a});
    end
    checks++;
    if ({ia_a, wa_a, oa_a, od_a, ci_a} !== 26'b0) begin
      errors++; $display("FAIL mid_rst_values got %h exp 0", {ia_a, wa_a, oa_a, od_a, ci_a});
    end
    @(negedge clk) reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (we_a || busy_a) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mid_quiet got %0d active exp 0", bad); end
    run_pass(0, 1'b0);
    checks++;
    if (done_at !== 22 || wr_addr[0] !== 2'd0) begin
      errors++; $display("FAIL mid_restart got done %0d addr %0d exp 22 0", done_at, wr_addr[0]);
    end
  endtask

  task automatic test_busy_start;
    sel = 1'b0;
    run_pass(4, 1'b0);
    checks++;
    if (done_cnt !== 1 || done_at !== 22) begin
      errors++; $display("FAIL busy_done got cnt %0d at %0d exp 1 22", done_cnt, done_at);
    end
    checks++;
    if (rd_cnt !== 12 || rd_bad !== 0 || wr_cnt !== 3) begin
      errors++; $display("FAIL busy_seq got rd %0d bad %0d wr %0d exp 12 0 3",
                         rd_cnt, rd_bad, wr_cnt);
    end
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    run_pass(0, 1'b1);
    checks++;
    if (done_cnt !== 1 || busy_end !== 1'b0 || clr_after !== 24) begin
      errors++; $display("FAIL b2b got done %0d busy %b clr %0d exp 1 0 24",
                         done_cnt, busy_end, clr_after);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_full;
    int exp_data [0:9];
    int s, v, best, bidx, got_done, nwr, bad_addr, bad_data;
    best = 0; bidx = 0;
    for (int j = 0; j < 10; j++) begin
      s = 0;
      for (int i = 0; i < 784; i++) s += xval(i) * wval(j * 784 + i);
      v = s >>> 8;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      if (j == 0 || v > best) begin best = v; bidx = j; end
      exp_data[j] = (v < 0) ? 0 : v;
    end
    got_done = 0; nwr = 0; bad_addr = 0; bad_data = 0;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    for (int k = 1; k <= 8000; k++) begin
      if (we_c) begin
        if (nwr < 10) begin
          if (oa_c !== 4'(nwr)) bad_addr++;
          if (od_c !== 16'(exp_data[nwr])) bad_data++;
        end
        nwr++;
      end
      if (done_c && got_done == 0) got_done = k;
      if (got_done != 0 && k == got_done + 1) break;
      @(negedge clk);
    end
    checks++;
    if (got_done !== 7871) begin errors++; $display("FAIL full_done got %0d exp 7871", got_done); end
    checks++;
    if (nwr !== 10 || bad_addr !== 0) begin
      errors++; $display("FAIL full_writes got %0d bad addr %0d exp 10 0", nwr, bad_addr);
    end
    checks++;
    if (bad_data !== 0) begin errors++; $display("FAIL full_data got %0d bad exp 0", bad_data); end
    checks++;
    if (ci_c !== 4'(bidx) || cv_c !== 1'b1) begin
      errors++; $display("FAIL full_class got %0d cv %b exp %0d 1", ci_c, cv_c, bidx);
    end
  endtask

  initial begin
    sel = 1'b0;
    start_s = 1'b0;
    start_c = 1'b0;
    tab[0] = '0; tab[1] = '0; tab[2] = '0; tab[3] = '0;
    test_reset_state();
    test_sequencing();
    test_arith();
    test_argmax();
    test_reset_midrun();
    test_busy_start();
    test_back_to_back();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
